// File: rtl/range_count_ctrl.sv
// Bounded range counter sequencer: programmable lo/hi bounds, start/stop/pause
// control, continuous or one-shot runs. Optional DOWN_COUNT_EN adds a dir input.
module range_count_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEF_LO = 5,
    parameter int unsigned DEF_HI = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             oneshot,
`ifdef DOWN_COUNT_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] RESET_LO = DEF_LO[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_HI = DEF_HI[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] loBound_q, loBound_d;
    logic [WIDTH-1:0] hiBound_q, hiBound_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             oneshot_q, oneshot_d;
    logic             downDir_q, downDir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             cfgErr_q, cfgErr_d;

    logic             dirIn;
    logic [WIDTH-1:0] endBound;
    logic [WIDTH-1:0] reloadBound;
    logic [WIDTH-1:0] steppedCount;

`ifdef DOWN_COUNT_EN
    assign dirIn = dir;
`else
    assign dirIn = 1'b0;
`endif

    // Direction picks which bound terminates a pass and which one the count
    // reloads to; the count never leaves [lo, hi] so the step cannot wrap.
    assign endBound     = downDir_q ? loBound_q : hiBound_q;
    assign reloadBound  = downDir_q ? hiBound_q : loBound_q;
    assign steppedCount = downDir_q ? (count_q - ONE) : (count_q + ONE);

    always_comb begin
        state_d   = state_q;
        loBound_d = loBound_q;
        hiBound_d = hiBound_q;
        count_d   = count_q;
        oneshot_d = oneshot_q;
        downDir_d = downDir_q;
        cfgErr_d  = cfgErr_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A config write in the same cycle as start wins; start is dropped.
                if (cfg_we) begin
                    if (cfg_lo <= cfg_hi) begin
                        loBound_d = cfg_lo;
                        hiBound_d = cfg_hi;
                        count_d   = cfg_lo;
                        cfgErr_d  = 1'b0;
                    end else begin
                        cfgErr_d  = 1'b1;
                    end
                end else if (start && !stop) begin
                    state_d   = RUN;
                    oneshot_d = oneshot;
                    downDir_d = dirIn;
                    count_d   = dirIn ? hiBound_q : loBound_q;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = loBound_q;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (count_q == endBound) begin
                    if (oneshot_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = reloadBound;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = steppedCount;
                end
            end

            HOLD: begin
                // Leaving HOLD takes one edge with the count still frozen.
                if (stop) begin
                    state_d = IDLE;
                    count_d = loBound_q;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = loBound_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            loBound_q <= RESET_LO;
            hiBound_q <= RESET_HI;
            count_q   <= RESET_LO;
            oneshot_q <= 1'b0;
            downDir_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            cfgErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            loBound_q <= loBound_d;
            hiBound_q <= hiBound_d;
            count_q   <= count_d;
            oneshot_q <= oneshot_d;
            downDir_q <= downDir_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            cfgErr_q  <= cfgErr_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign cfg_err = cfgErr_q;

endmodule

// File: tb/tb_range_count_ctrl.sv
// Self-checking bench for range_count_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_range_count_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_lo;
    logic [3:0] cfg_hi;
    logic       start;
    logic       stop;
    logic       pause;
    logic       oneshot;
    logic       dir;
    logic [3:0] count;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       cfg_err;

    int total = 0;
    int bad   = 0;

    range_count_ctrl #(.WIDTH(4), .DEF_LO(5), .DEF_HI(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_lo  (cfg_lo),
        .cfg_hi  (cfg_hi),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .oneshot (oneshot),
`ifdef DOWN_COUNT_EN
        .dir     (dir),
`endif
        .count   (count),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: bounds, a running flag, a paused flag and an
    // integer count stepped by plain arithmetic.
    int mLo, mHi, mCount;
    bit mActive, mPaused, mOneshot, mDown, mWrap, mDone, mErr;

    function automatic void modelStep();
        int lastVal;
        bit dirBit;
`ifdef DOWN_COUNT_EN
        dirBit = dir;
`else
        dirBit = 1'b0;
`endif
        mWrap = 0;
        mDone = 0;
        if (rst) begin
            mLo = 5; mHi = 15; mCount = 5;
            mActive = 0; mPaused = 0; mErr = 0; mOneshot = 0; mDown = 0;
        end else if (!mActive) begin
            if (cfg_we) begin
                if (int'(cfg_lo) <= int'(cfg_hi)) begin
                    mLo = int'(cfg_lo); mHi = int'(cfg_hi); mCount = mLo; mErr = 0;
                end else begin
                    mErr = 1;
                end
            end else if (start && !stop) begin
                mActive = 1; mPaused = 0; mOneshot = oneshot; mDown = dirBit;
                mCount = mDown ? mHi : mLo;
            end
        end else if (stop) begin
            mActive = 0; mPaused = 0; mCount = mLo;
        end else if (mPaused) begin
            if (!pause) mPaused = 0;
        end else if (pause) begin
            mPaused = 1;
        end else begin
            lastVal = mDown ? mLo : mHi;
            if (mCount == lastVal) begin
                if (mOneshot) begin
                    mActive = 0; mDone = 1;
                end else begin
                    mCount = mDown ? mHi : mLo; mWrap = 1;
                end
            end else begin
                mCount = mDown ? mCount - 1 : mCount + 1;
            end
        end
    endfunction

    task automatic checkField(input string tag, input string field, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s.%s: got %0d want %0d at %0t", tag, field, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input int eCount, input bit eBusy,
                               input bit eWrap, input bit eDone, input bit eErr);
        checkField(tag, "count", int'(count), eCount);
        checkField(tag, "busy", int'(busy), int'(eBusy));
        checkField(tag, "wrap", int'(wrap), int'(eWrap));
        checkField(tag, "done", int'(done), int'(eDone));
        checkField(tag, "cfg_err", int'(cfg_err), int'(eErr));
    endtask

    task automatic applyStimulus(input bit r, input bit we, input logic [3:0] lo, input logic [3:0] hi,
                                 input bit st, input bit sp, input bit pz, input bit os, input bit dr);
        rst = r; cfg_we = we; cfg_lo = lo; cfg_hi = hi;
        start = st; stop = sp; pause = pz; oneshot = os; dir = dr;
    endtask

    // One clock with the current inputs; outputs compared to the model #1 after the edge.
    task automatic tick(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag, mCount, mActive, mWrap, mDone, mErr);
    endtask

    task automatic idleTick(input string tag);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, dir);
        tick(tag);
    endtask

    typedef struct {
        bit         r, we;
        logic [3:0] lo, hi;
        bit         st, sp, pz, os;
        int         eCount;
        bit         eBusy, eWrap, eDone, eErr;
    } vec_t;

    vec_t vecs[24];

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;

        vecs[0]  = '{1, 0, 4'd0, 4'd0, 0, 0, 0, 0, 5, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 4'd9, 4'd2, 0, 0, 0, 0, 5, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, 4'd2, 4'd9, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 4'd3, 4'd7, 0, 0, 0, 0, 3, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 4'd0, 4'd0, 1, 0, 0, 1, 3, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 4, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 5, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 6, 1, 0, 0, 0};
        vecs[8]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 7, 1, 0, 0, 0};
        vecs[9]  = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 7, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 7, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 4'd0, 4'd0, 1, 0, 0, 0, 3, 1, 0, 0, 0};
        vecs[12] = '{0, 0, 4'd0, 4'd0, 1, 0, 0, 0, 4, 1, 0, 0, 0};
        vecs[13] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 5, 1, 0, 0, 0};
        vecs[14] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 6, 1, 0, 0, 0};
        vecs[15] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 7, 1, 0, 0, 0};
        vecs[16] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 3, 1, 1, 0, 0};
        vecs[17] = '{0, 1, 4'd9, 4'd2, 0, 0, 0, 0, 4, 1, 0, 0, 0};
        vecs[18] = '{0, 0, 4'd0, 4'd0, 0, 1, 0, 0, 3, 0, 0, 0, 0};
        vecs[19] = '{0, 1, 4'd1, 4'd2, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[20] = '{0, 0, 4'd0, 4'd0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[21] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 2, 1, 0, 0, 0};
        vecs[22] = '{0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        vecs[23] = '{0, 0, 4'd0, 4'd0, 0, 1, 1, 0, 1, 0, 0, 0, 0};

        $display("[TB] vector table");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].r, vecs[i].we, vecs[i].lo, vecs[i].hi,
                          vecs[i].st, vecs[i].sp, vecs[i].pz, vecs[i].os, 0);
            modelStep();
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].eCount, vecs[i].eBusy,
                        vecs[i].eWrap, vecs[i].eDone, vecs[i].eErr);
        end

        $display("[TB] continuous 5..15 wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_a");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick("start_a");
        checkOutput("start_a_exp", 5, 1, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            idleTick("cont");
            checkOutput("cont_exp", (i <= 9) ? 6 + i : i - 5, 1, (i == 10), 0, 0);
        end

        $display("[TB] pause and stop");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_b");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick("start_b");
        for (int i = 0; i < 3; i++) idleTick("to8");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
            tick("paused");
            checkOutput("paused_exp", 8, 1, 0, 0, 0);
        end
        idleTick("unpause0");
        checkOutput("unpause0_exp", 8, 1, 0, 0, 0);
        idleTick("unpause1");
        checkOutput("unpause1_exp", 9, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0);
        tick("stop_pause");
        checkOutput("stop_pause_exp", 5, 0, 0, 0, 0);

        $display("[TB] lo==hi and reset mid-run");
        applyStimulus(0, 1, 4'd4, 4'd4, 0, 0, 0, 0, 0);
        tick("cfg44");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick("start44");
        for (int i = 0; i < 4; i++) begin
            idleTick("eq_cont");
            checkOutput("eq_cont_exp", 4, 1, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tick("stop44");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0);
        tick("start44_os");
        idleTick("eq_os");
        checkOutput("eq_os_exp", 4, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_c");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tick("start_c");
        for (int i = 0; i < 5; i++) idleTick("to10");
        checkOutput("at10_exp", 10, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_mid");
        checkOutput("rst_mid_exp", 5, 0, 0, 0, 0);

`ifdef DOWN_COUNT_EN
        $display("[TB] down count");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tick("start_dn");
        checkOutput("start_dn_exp", 15, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            idleTick("dn");
            checkOutput("dn_exp", (i < 10) ? 14 - i : 15, 1, (i == 10), 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tick("stop_dn");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
        tick("start_dn_os");
        for (int i = 0; i < 10; i++) idleTick("dn_os");
        idleTick("dn_done");
        checkOutput("dn_done_exp", 5, 0, 0, 1, 0);
`endif

        $display("[TB] randomized traffic");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_r");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 8) == 0,
                          4'($urandom), 4'($urandom),
                          ($urandom % 4) == 0, ($urandom % 32) == 0,
                          ($urandom % 6) == 0, 1'($urandom), 1'($urandom));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
